// File: rtl/sseg_scan_mux_if.sv
// Bundle between the value-producing logic and the seven-segment scan
// controller: display values and controls in, pin-level drive and scan status out.
interface sseg_scan_mux_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 2
);
  localparam int SEL_W = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lz_blank;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   sseg_anode;
  logic [7:0]              sseg_cathode;
  logic [SEL_W-1:0]        digit_sel;
  logic                    frame_tick;

  // Value producer side.
  modport master (
    output digits, dp_in, blank, lz_blank, brightness,
    input  sseg_anode, sseg_cathode, digit_sel, frame_tick
  );

  // Scan controller side.
  modport slave (
    input  digits, dp_in, blank, lz_blank, brightness,
    output sseg_anode, sseg_cathode, digit_sel, frame_tick
  );
endinterface

// File: rtl/sseg_scan_mux.sv
// Multiplexed N-digit common-anode seven-segment scan controller with
// frame-coherent input snapshots, hex decode, per-digit blank/dp,
// leading-zero suppression and PWM brightness.
module sseg_scan_mux #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 5000,
  parameter int BRIGHT_W    = 2
) (
  input logic            clk,
  input logic            rst_n,
  sseg_scan_mux_if.slave bus
);

  localparam int SEL_W  = $clog2(NUM_DIGITS);
  localparam int PCNT_W = $clog2(REFRESH_DIV);
  localparam int STEP   = REFRESH_DIV >> BRIGHT_W;

  // Active-low a..g pattern for a hex nibble (dp handled separately).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
    case (val)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  logic [PCNT_W-1:0]       r_pcnt;
  logic [SEL_W-1:0]        r_sel;
  logic [4*NUM_DIGITS-1:0] r_s_digits;
  logic [NUM_DIGITS-1:0]   r_s_dp;
  logic [NUM_DIGITS-1:0]   r_s_blank;
  logic                    r_s_lz;
  logic [BRIGHT_W-1:0]     r_s_bright;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [7:0]              r_cathode;

  logic                    w_tick;
  logic                    w_wrap;
  logic [NUM_DIGITS-1:0]   w_supp;
  logic                    w_run;
  logic                    w_dark;
  logic [PCNT_W:0]         w_on_lim;
  logic                    w_on;
  logic [3:0]              w_nibble;

  assign w_tick = (r_pcnt == PCNT_W'(REFRESH_DIV - 1));
  assign w_wrap = w_tick && (r_sel == SEL_W'(NUM_DIGITS - 1));

  // Prescaler and digit scan counter; the digit index steps once per slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_sel  <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
      r_sel  <= w_wrap ? '0 : r_sel + SEL_W'(1);
    end else begin
      r_pcnt <= r_pcnt + PCNT_W'(1);
    end
  end

  // Frame-coherent snapshot: inputs are only sampled on the wrapping tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_digits <= '0;
      r_s_dp     <= '0;
      r_s_blank  <= '0;
      r_s_lz     <= 1'b0;
      r_s_bright <= '1;
    end else if (w_wrap) begin
      r_s_digits <= bus.digits;
      r_s_dp     <= bus.dp_in;
      r_s_blank  <= bus.blank;
      r_s_lz     <= bus.lz_blank;
      r_s_bright <= bus.brightness;
    end
  end

  // Leading-zero run from the top digit down; blanked digits count as zero
  // and digit 0 always stays visible.
  always_comb begin
    w_run  = 1'b1;
    w_supp = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run     = w_run & (r_s_blank[i] | (r_s_digits[4*i +: 4] == 4'd0));
      w_supp[i] = r_s_lz & w_run & (i != 0);
    end
  end

  assign w_nibble = r_s_digits[4*r_sel +: 4];
  assign w_dark   = r_s_blank[r_sel] | w_supp[r_sel];
  assign w_on_lim = (PCNT_W+1)'((int'(r_s_bright) + 1) * STEP);
  assign w_on     = ({1'b0, r_pcnt} < w_on_lim);

  // Registered pin drive; the PWM window gates the anode only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_anode   <= '1;
      r_cathode <= 8'hFF;
    end else if (w_dark) begin
      r_anode   <= '1;
      r_cathode <= 8'hFF;
    end else begin
      r_anode   <= w_on ? ~(NUM_DIGITS'(1) << r_sel) : '1;
      r_cathode <= {~r_s_dp[r_sel], hex_to_seg(w_nibble)};
    end
  end

  assign bus.sseg_anode   = r_anode;
  assign bus.sseg_cathode = r_cathode;
  assign bus.digit_sel    = r_sel;
  assign bus.frame_tick   = w_wrap & rst_n;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed-plus-random bench for sseg_scan_mux against a frame/slot model
// computed from the elapsed cycle count since reset.
module tb_sseg_scan_mux;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BW = 2;
  localparam int FR = N * RD;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sseg_scan_mux_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();

  sseg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BRIGHT_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: cycles since reset and the captured frame inputs.
  int          t = 0;
  bit          known = 1'b0;
  logic [15:0] s_dig;
  logic [3:0]  s_dp, s_bl;
  logic        s_lz;
  logic [1:0]  s_br;
  int          lowcnt;

  logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Expected pins for the slot position and snapshot at cycle t.
  task automatic model(output logic [3:0] an, output logic [7:0] ca);
    int  sel, pc, hi;
    bit  dark;
    logic [15:0] sh;
    sel = (t / RD) % N;
    pc  = t % RD;
    hi  = -1;
    for (int i = 0; i < N; i++)
      if (!s_bl[i] && ((s_dig >> (4*i)) & 16'hF) != 0) hi = i;
    dark = s_bl[sel] || (s_lz && sel > hi && sel != 0);
    sh   = s_dig >> (4*sel);
    if (dark) begin
      an = 4'hF;
      ca = 8'hFF;
    end else begin
      an = (pc < (int'(s_br) + 1) * (RD >> BW)) ? ~(4'b0001 << sel) : 4'hF;
      ca = SEG[sh[3:0]];
      if (s_dp[sel]) ca[7] = 1'b0;
    end
  endtask

  task automatic step();
    logic [3:0]  ea, in_dp, in_bl;
    logic [7:0]  ec;
    logic [15:0] in_dig;
    logic        in_lz;
    logic [1:0]  in_br;
    bit          rst_now, wrap;
    if (known) begin
      chk("digit_sel", 32'(bus.digit_sel), (t / RD) % N);
      chk("frame_tick", 32'(bus.frame_tick), 32'(rst_n && (t % FR == FR - 1)));
    end
    rst_now = !rst_n;
    wrap    = (t % FR == FR - 1);
    in_dig = bus.digits; in_dp = bus.dp_in; in_bl = bus.blank;
    in_lz  = bus.lz_blank; in_br = bus.brightness;
    if (rst_now) begin
      ea = 4'hF;
      ec = 8'hFF;
    end else begin
      model(ea, ec);
    end
    @(posedge clk);
    if (rst_now) begin
      t = 0;
      s_dig = '0; s_dp = '0; s_bl = '0; s_lz = 1'b0; s_br = '1;
    end else begin
      if (wrap) begin
        s_dig = in_dig; s_dp = in_dp; s_bl = in_bl; s_lz = in_lz; s_br = in_br;
      end
      t++;
    end
    known = 1'b1;
    #1;
    chk("anode", 32'(bus.sseg_anode), 32'(ea));
    chk("cathode", 32'(bus.sseg_cathode), 32'(ec));
    chk("one_anode", 32'($countones(~bus.sseg_anode) <= 1), 32'd1);
    if (bus.sseg_anode != 4'hF) lowcnt++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic align();
    int g = 0;
    while (t % FR != 0 && g < 2 * FR) begin
      step();
      g++;
    end
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                        input logic lz, input logic [1:0] br);
    bus.digits = d; bus.dp_in = dp; bus.blank = bl; bus.lz_blank = lz; bus.brightness = br;
  endtask

  initial begin
    int guard;
    // Reset with random inputs.
    rst_n = 1'b0;
    set_in(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
    run(3);
    chk("rst_sel", 32'(bus.digit_sel), 32'd0);
    chk("rst_ftick", 32'(bus.frame_tick), 32'd0);
    rst_n = 1'b1;
    step();
    chk("first_cath", 32'(bus.sseg_cathode), 32'hC0);
    chk("first_anode", 32'(bus.sseg_anode), 32'hE);
    lowcnt = 0;
    run(RD - 1);
    chk("first_full_duty", lowcnt, RD - 1);

    // Scan pattern with a dp on digit 1, full brightness.
    set_in(16'h1234, 4'b0010, 4'b0000, 1'b0, 2'd3);
    align();
    lowcnt = 0;
    run(FR);
    chk("duty_b3", lowcnt, FR);

    // Brightness 0 and 2.
    set_in(16'h1234, 4'b0010, 4'b0000, 1'b0, 2'd0);
    align(); run(FR);
    lowcnt = 0; run(FR);
    chk("duty_b0", lowcnt, 2 * N);
    set_in(16'h1234, 4'b0010, 4'b0000, 1'b0, 2'd2);
    align(); run(FR);
    lowcnt = 0; run(FR);
    chk("duty_b2", lowcnt, 6 * N);

    // Leading-zero suppression.
    set_in(16'h0050, 4'b0000, 4'b0000, 1'b1, 2'd3);
    align(); run(FR);
    lowcnt = 0; run(FR);
    chk("lz_0050_lit", lowcnt, 2 * RD);
    set_in(16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3);
    align(); run(FR);
    lowcnt = 0; run(FR);
    chk("lz_0000_lit", lowcnt, RD);

    // Mid-frame input change must wait for the next frame.
    set_in(16'h1111, 4'b0000, 4'b0000, 1'b0, 2'd3);
    align(); run(FR);
    run(12);
    bus.digits = 16'h2222;
    step();
    chk("snap_hold", 32'(bus.sseg_cathode), 32'hF9);
    align();
    step();
    chk("snap_new", 32'(bus.sseg_cathode), 32'hA4);
    run(FR - 1);

    // Randomised inputs changing at arbitrary cycles.
    for (int k = 0; k < 15 * FR; k++) begin
      if ($urandom_range(7) == 0)
        set_in(16'($urandom), 4'($urandom), 4'($urandom_range(3) == 0 ? $urandom : 0),
               1'($urandom), 2'($urandom));
      step();
    end

    // Mid-frame reset while digit 2 is being scanned.
    set_in(16'h9876, 4'b0101, 4'b0000, 1'b0, 2'd3);
    align(); run(FR);
    guard = 0;
    while (bus.digit_sel !== 2'd2 && guard < 4 * FR) begin
      step();
      guard++;
    end
    chk("reach_sel2", 32'(guard < 4 * FR), 32'd1);
    run(3);
    rst_n = 1'b0;
    step();
    chk("mid_rst_anode", 32'(bus.sseg_anode), 32'hF);
    chk("mid_rst_cath", 32'(bus.sseg_cathode), 32'hFF);
    rst_n = 1'b1;
    step();
    chk("restart_sel0_anode", 32'(bus.sseg_anode), 32'hE);
    chk("restart_cath", 32'(bus.sseg_cathode), 32'hC0);
    run(2 * FR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
